// File: rtl/mrv32_pkg.sv
// mrv32_pkg: shared constants for the mrv32 simulation control block
package mrv32_pkg;
  localparam int MRV32_ADDR_WIDTH = 32;
  localparam logic [31:0] SIMCTRL_BASE = 32'h0001_0000;
  localparam logic [3:0] SIMCTRL_CONSOLE = 4'h0;
  localparam logic [3:0] SIMCTRL_TOHOST = 4'h4;
  localparam logic [3:0] SIMCTRL_CYCLE_LO = 4'h8;
  localparam logic [3:0] SIMCTRL_CYCLE_HI = 4'hC;
  localparam logic [3:0] WSTRB_FULL = 4'hF;
endpackage

// File: rtl/mrv32_sim_ctrl_if.sv
// mrv32_sim_ctrl_if: mrv32 data port B request/response bundle
interface mrv32_sim_ctrl_if import mrv32_pkg::*; #(
  parameter int ADDR_WIDTH = MRV32_ADDR_WIDTH
);
  logic valid;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic [31:0] rdata;
  logic rvalid;
  modport master(output valid, addr, wdata, wstrb, input rdata, rvalid);
  modport slave(input valid, addr, wdata, wstrb, output rdata, rvalid);
endinterface

// File: rtl/mrv32_sync_fifo.sv
// mrv32_sync_fifo: synchronous FIFO, power-of-2 depth, head shown combinationally
module mrv32_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  // a pop on a full FIFO frees the slot for a same-cycle push
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/mrv32_sim_ctrl.sv
// mrv32_sim_ctrl: memory-mapped console, TOHOST and cycle counter responder
module mrv32_sim_ctrl import mrv32_pkg::*; #(
  parameter int ADDR_WIDTH = MRV32_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(SIMCTRL_BASE),
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  mrv32_sim_ctrl_if.slave bus,
  input  logic        con_ready,
  output logic        con_valid,
  output logic [7:0]  con_data,
  output logic        sim_done,
  output logic        sim_pass,
  output logic [30:0] sim_code,
  output logic        con_overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [63:0] cnt;
  logic [31:0] hi_snap, tohost, rd_c;
  logic [3:0] off;
  logic hit, rd_req, wr_req, push, drop, full, empty;
  logic [CW-1:0] count;
  logic [RD_LATENCY-1:0] rv_q;
  logic [31:0] rd_q [RD_LATENCY];
  logic unused_ok;
  assign unused_ok = ^bus.addr[1:0];
  assign hit = bus.addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4];
  assign off = {bus.addr[3:2], 2'b00};
  assign rd_req = bus.valid && bus.wstrb == 4'h0;
  assign wr_req = bus.valid && |bus.wstrb && hit;
  assign push = wr_req && off == SIMCTRL_CONSOLE && bus.wstrb[0];
  // full implies non-empty, so a ready consumer always makes room
  assign drop = push && full && !con_ready;
  always_comb
    rd_c = !hit ? 32'h0 :
           off == SIMCTRL_CONSOLE ? {16'(count), 15'b0, full} :
           off == SIMCTRL_TOHOST ? tohost :
           off == SIMCTRL_CYCLE_LO ? cnt[31:0] : hi_snap;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      hi_snap <= '0;
      tohost <= '0;
      sim_done <= 1'b0;
      con_overflow <= 1'b0;
      rv_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rd_q[i] <= '0;
    end else begin
      cnt <= cnt + 64'd1;
      if (rd_req && hit && off == SIMCTRL_CYCLE_LO) hi_snap <= cnt[63:32];
      if (wr_req && off == SIMCTRL_TOHOST && bus.wstrb == WSTRB_FULL && !sim_done) begin
        tohost <= bus.wdata;
        sim_done <= 1'b1;
      end
      if (drop) con_overflow <= 1'b1;
      rv_q[0] <= rd_req;
      rd_q[0] <= rd_req ? rd_c : 32'h0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rv_q[i] <= rv_q[i-1];
        rd_q[i] <= rd_q[i-1];
      end
    end
  end
  assign bus.rvalid = rv_q[RD_LATENCY-1];
  assign bus.rdata = rd_q[RD_LATENCY-1];
  assign sim_pass = tohost == 32'd1;
  assign sim_code = tohost[31:1];
  assign con_valid = !empty;
  mrv32_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(bus.wdata[7:0]),
    .pop(con_ready),
    .dout(con_data),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: doc/mrv32_sim_ctrl.md
# mrv32_sim_ctrl

Memory-mapped simulation control responder for the mrv32 data port (port B protocol: valid/addr/wdata/wstrb → rdata/rvalid). It sits beside `dual_port_byte_mem` on the data bus and gives software three services: a byte-wide console stream, a TOHOST pass/fail register, and a 64-bit cycle counter. It ends a simulation on software command, so the bench no longer relies on a cycle limit or `unsupported_instr`.

## Interface
- `ADDR_WIDTH`, default from `mrv32_pkg`: request address width.
- `BASE_ADDR`, default 32'h0001_0000: base of the 16-byte register window; must be 16-byte aligned.
- `RD_LATENCY`, default 2: cycles from read request to `rvalid`; must be ≥1.
- `FIFO_DEPTH`, default 8: depth of the console FIFO; must be a power of 2.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `valid` input 1: request strobe. No ready signal; a request is accepted every cycle `valid`=1.
- `addr` input ADDR_WIDTH: byte address.
- `wdata` input 32: write data.
- `wstrb` input 4: byte enables. Nonzero means write; 0 means read.
- `rdata` output 32: read data; meaningful only while `rvalid`=1.
- `rvalid` output 1: read response strobe, one cycle per read.
- `con_valid` output 1: console byte available.
- `con_data` output 8: console byte; head of the FIFO.
- `con_ready` input 1: the consumer takes the byte when `con_valid`&&`con_ready`.
- `sim_done` output 1: sticky; TOHOST has been written.
- `sim_pass` output 1: TOHOST value == 1.
- `sim_code` output 31: TOHOST[31:1], the failing test number.
- `con_overflow` output 1: sticky; a console byte was dropped.

## Operation
- Window hit when `addr[ADDR_WIDTH-1:4]` == `BASE_ADDR[ADDR_WIDTH-1:4]`. Offset = `addr[3:2]`. `addr[1:0]` is ignored.
- Offset 0x0, CONSOLE:
  - Write with `wstrb[0]`=1 pushes `wdata[7:0]` into the FIFO.
  - Read returns {count[15:0] in [31:16], 15'b0, full in [0]}.
- Offset 0x4, TOHOST:
  - A write with `wstrb`=4'hF while `sim_done`=0 latches `wdata` and sets `sim_done`.
  - Later writes are ignored. Partial-strobe writes are ignored.
  - Read returns the latched value.
- Offset 0x8, CYCLE_LO:
  - Read returns `cnt[31:0]` and captures `cnt[63:32]` into the HI snapshot in the same cycle.
  - Writes are ignored.
- Offset 0xC, CYCLE_HI: read returns the snapshot from the last CYCLE_LO read. Writes are ignored.
- `cnt` is a 64-bit counter:
  - Increments every cycle after reset and wraps at 2^64−1.
  - A read at cycle t returns the value of `cnt` at cycle t.
- Misses:
  - Writes outside the window are ignored.
  - Reads outside the window return 0 with a normal `rvalid`, so the core never hangs.
- Console FIFO:
  - A push when the FIFO is full is dropped and sets `con_overflow`.
  - A push and a pop in the same cycle on a full FIFO: the pop frees a slot and the push is accepted.
  - A push and a pop in the same cycle on an empty FIFO: the byte goes into storage and is not bypassed.
  - Pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Read data is formed combinationally in the request cycle t. It travels through a `RD_LATENCY`-stage valid/data shift register. `rvalid`=1 and `rdata` are presented in cycle t+`RD_LATENCY`.
- Back-to-back reads give back-to-back `rvalid` in request order.
- Writes take effect at the edge ending the request cycle. A CONSOLE write in cycle t makes `con_valid`=1 in t+1. Writes produce no `rvalid`.
- Reads see register state from before the write in the same cycle.
- `sim_done`, `sim_pass` and `sim_code` are registered: a TOHOST write in cycle t makes them visible in t+1.
- Reset values: `rvalid`=0, `rdata`=0, `con_valid`=0, `con_data`=0, `sim_done`=0, `sim_pass`=0, `sim_code`=0, `con_overflow`=0. Also `cnt`=0, the HI snapshot=0, and the FIFO empty.
- Reset mid-operation: in-flight reads are discarded, so no `rvalid` appears in the cycle after reset. The FIFO contents are lost.

## Structure
- `mrv32_pkg` holds:
  - offset constants `SIMCTRL_CONSOLE`, `SIMCTRL_TOHOST`, `SIMCTRL_CYCLE_LO`, `SIMCTRL_CYCLE_HI`;
  - `SIMCTRL_BASE`.
- Sub-module `mrv32_sync_fifo` (parameters WIDTH, DEPTH):
  - push/pop, `count`, `full`, `empty`; synchronous active-high reset;
  - reused later for UART transmit.
- Top level: address decode, register file, counter and read pipeline.

## Test plan
- Reset, then read CYCLE_LO then CYCLE_HI (`RD_LATENCY`=2) → two `rvalid` pulses 2 cycles after each request. HI=0. LO equals the number of cycles since reset deasserted at the request cycle.
- Write 0x48 then 0x69 to CONSOLE with `con_ready`=0 → read CONSOLE returns 0x0002_0000. Raise `con_ready` → `con_data` is 0x48 then 0x69, then `con_valid`=0.
- Write 9 bytes with `con_ready`=0 and `FIFO_DEPTH`=8 → `con_overflow`=1 and the 9th byte is lost. With full FIFO plus simultaneous push and pop → count stays 8 and `con_overflow` does not set.
- Write TOHOST=1 → `sim_done`=`sim_pass`=1 next cycle. After reset, write TOHOST=0x7 → `sim_pass`=0, `sim_code`=3. A second write of 1 is ignored.
- Read at `BASE_ADDR`+0x20 → `rdata`=0 with `rvalid`. Write with `wstrb`=4'h3 to TOHOST → `sim_done` stays 0.
- Issue a read, then assert `rst` one cycle later → no `rvalid` after reset. All outputs are 0 in the first cycle after `rst` is released.
